vga_row_pattern_gen: RTL and testbench
======================================

# vga_row_pattern_gen

Parametrised VGA timing generator with a row-banded pattern renderer, driving 2-bit-per-channel RGB plus active-low syncs to the VGA PMOD from the TinyTapeout user top. Generalises the row-by-row VGA project into configurable timing, band height, colour depth and pattern modes, and adds frame-synchronous control shadowing and vertical scrolling. Instantiated once in the top; its outputs map directly onto `uo_out`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal porch and sync widths, in clocks
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical porch and sync widths, in lines
- `ROW_SHIFT`, 4: band height is 2^ROW_SHIFT lines
- `CW`, 2: bits per colour channel
- `clk  in  1`: pixel clock. Single clock domain.
- `rst_n  in  1`: reset, asynchronous, active-low
- `ena  in  1`: when low, all state freezes and outputs hold
- `mode  in  2`: 0 black, 1 solid, 2 row bands, 3 checker
- `base_color  in  3*CW`: {R,G,B} seed colour
- `scroll_en  in  1`: advance the vertical scroll offset once per frame
- `hsync  out  1`, `vsync  out  1`: active-low syncs
- `de  out  1`: display enable (pixel is visible)
- `r`, `g`, `b  out  CW each`: colour channels. Forced to 0 when `de`=0.
- `frame_start  out  1`: one-cycle pulse at hpos=0, vpos=0
- `hpos  out  clog2(H_TOTAL)`, `vpos  out  clog2(V_TOTAL)`: current counters, unregistered

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V parameters.
- **Counters**
  - `hpos` counts 0..H_TOTAL-1 and wraps to 0.
  - `vpos` increments on the hpos wrap and wraps to 0 after V_TOTAL-1.
- **Sync and enable decode**
  - hsync is low for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync is decoded the same way from vpos and the V parameters.
  - de = (hpos<H_ACTIVE) && (vpos<V_ACTIVE).
- **Shadow registers**
  - `mode`, `base_color` and `scroll_en` are captured into shadow registers only on the cycle where hpos=0 and vpos=0.
  - Mid-frame changes therefore take effect at the next frame, with no tearing.
- **Scroll offset**
  - `offset` has width clog2(V_TOTAL).
  - If shadow scroll_en=1, offset increments at the frame-start cycle, wrapping from V_TOTAL-1 to 0.
- **Band index**
  - y' = vpos+offset; if y' ≥ V_TOTAL, subtract V_TOTAL.
  - band = y' >> ROW_SHIFT, truncated to 3*CW bits.
- **Colour, computed with mod-2^(3*CW) arithmetic on {R,G,B}**
  - mode 0: 0.
  - mode 1: base_color.
  - mode 2: base_color + band.
  - mode 3: base_color ^ {3*CW{band[0] ^ hpos[ROW_SHIFT]}}.
- **Freeze:** with ena=0, counters, offset, shadows and outputs hold; frame_start is 0.

## Timing
- **Output registration:** hsync, vsync, de, r, g, b and frame_start are registered. They correspond to the counter values of the previous cycle (1-clock latency), so sync and colour stay aligned.
- **Reset values**
  - counters = 0, offset = 0, shadows = 0 (mode black).
  - hsync = 1, vsync = 1, de = 0, rgb = 0, frame_start = 0.
- **Reset deasserted mid-frame:** the block restarts at hpos=0, vpos=0. The first frame_start pulse appears one cycle after the first enabled clock.
- **ena transitions:** ena falling then rising resumes exactly where it froze. There are no skipped or duplicated pixels.
- **Frame-start collision:** shadow load and offset increment happen on the same frame-start cycle. The new scroll_en affects the increment at the following frame only.

## Structure
- **Package `vga_pkg`:**
  - mode enum (`VGA_BLACK`, `VGA_SOLID`, `VGA_ROWS`, `VGA_CHECK`).
  - default 640x480@60 timing localparams.
  - clog2 helper.
- **Sub-module `vga_timing`:** the counters, sync/de decode and frame_start. It takes the H/V parameters.
- **Top of this block:** shadows, scroll, pattern and output registers.

## Test plan
- **Reset:** hold rst_n low, toggle clk, then release → hsync=vsync=1, de=0, rgb=0. The first frame_start arrives 1 clk after release, and hpos increments every clock.
- **Line and frame timing (default parameters):**
  - hsync is low for exactly 96 clocks, starting at registered index 656 of each 800-clock line.
  - vsync is low on lines 490–491 of a 525-line frame.
  - de is high for 640x480 pixels per frame.
- **Row bands:** mode=2, base_color=6'h00, scroll off → lines 0–15 have rgb=0, lines 16–31 have {r,g,b}=6'h01, and line 479 has band 29 = 6'h1D.
- **Shadowing:** change base_color from 6'h00 to 6'h3F at vpos=100 in mode 1 → the current frame stays 0, and the next frame is all 6'h3F after frame_start.
- **Scroll and wrap:** scroll_en=1, mode 2 for 2 frames → in frame 2, line 0 shows the band of y'=1. With offset preset to 524 (run 524 frames, or force), line 1 shows y'=0, i.e. band 0.
- **ena freeze:** drop ena for 50 clocks at hpos=300 → hpos, vpos and outputs are constant. After re-enable the line still has 800 clocks of enabled time.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode encoding, default 640x480@60 timing and width helper
package vga_pkg;

    typedef enum logic [1:0] {
        VGA_BLACK = 2'd0,
        VGA_SOLID = 2'd1,
        VGA_ROWS  = 2'd2,
        VGA_CHECK = 2'd3
    } vga_mode_e;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int vga_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel/line counters with registered sync, enable and frame-start decode
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = vga_clog2(H_TOTAL),
    localparam int VW      = vga_clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          at_origin,
    output logic          visible,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        frame_start_d = 1'b0;
        at_origin     = (hpos_q == '0) && (vpos_q == '0);
        visible       = (hpos_q < H_VIS) && (vpos_q < V_VIS);
        if (ena) begin
            hpos_d = (hpos_q == H_LAST) ? '0 : hpos_q + 1'b1;
            if (hpos_q == H_LAST) begin
                vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
            end
            // Decoded from the pre-increment position so every output lags the counters by one clock.
            hsync_d       = !((hpos_q >= HS_START) && (hpos_q <= HS_END));
            vsync_d       = !((vpos_q >= VS_START) && (vpos_q <= VS_END));
            de_d          = visible;
            frame_start_d = at_origin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/vga_row_pattern_gen.sv
// rtl/vga_row_pattern_gen.sv - frame-shadowed controls, vertical scroll and row-band pattern renderer
module vga_row_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int ROW_SHIFT = 4,
    parameter int CW        = 2,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = vga_clog2(H_TOTAL),
    localparam int VW       = vga_clog2(V_TOTAL)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [1:0]      mode,
    input  logic [3*CW-1:0] base_color,
    input  logic            scroll_en,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b,
    output logic            frame_start,
    output logic [HW-1:0]   hpos,
    output logic [VW-1:0]   vpos
);

    localparam int PW  = 3 * CW;
    localparam int VWE = VW + 1;
    localparam logic [VW-1:0]  OFF_LAST = VW'(V_TOTAL - 1);
    localparam logic [VWE-1:0] VT_EXT   = VWE'(V_TOTAL);

    logic at_origin;
    logic visible;
    logic load;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .hpos        (hpos),
        .vpos        (vpos),
        .at_origin   (at_origin),
        .visible     (visible),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start)
    );

    vga_mode_e     mode_q, mode_d;
    logic [PW-1:0] color_q, color_d;
    logic          scroll_q, scroll_d;
    logic [VW-1:0] offset_q, offset_d;
    logic [PW-1:0] rgb_q, rgb_d;

    logic [VWE-1:0] y_sum;
    logic [VWE-1:0] y_wrap;
    logic [PW-1:0]  band;
    logic [PW-1:0]  pix;

    assign load = ena && at_origin;

    always_comb begin
        mode_d   = mode_q;
        color_d  = color_q;
        scroll_d = scroll_q;
        offset_d = offset_q;
        // The increment uses the outgoing frame's scroll flag; the newly captured one counts next frame.
        if (load) begin
            mode_d   = vga_mode_e'(mode);
            color_d  = base_color;
            scroll_d = scroll_en;
            if (scroll_q) begin
                offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
            end
        end
    end

    // Render with the *_d values so the frame's first pixel already sees the freshly loaded shadows.
    always_comb begin
        y_sum  = {1'b0, vpos} + {1'b0, offset_d};
        y_wrap = (y_sum >= VT_EXT) ? y_sum - VT_EXT : y_sum;
        band   = PW'(y_wrap >> ROW_SHIFT);
        pix    = '0;
        case (mode_d)
            VGA_BLACK: pix = '0;
            VGA_SOLID: pix = color_d;
            VGA_ROWS:  pix = color_d + band;
            VGA_CHECK: pix = color_d ^ {PW{band[0] ^ hpos[ROW_SHIFT]}};
            default:   pix = '0;
        endcase
        rgb_d = rgb_q;
        if (ena) begin
            rgb_d = visible ? pix : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= VGA_BLACK;
            color_q  <= '0;
            scroll_q <= 1'b0;
            offset_q <= '0;
            rgb_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            color_q  <= color_d;
            scroll_q <= scroll_d;
            offset_q <= offset_d;
            rgb_q    <= rgb_d;
        end
    end

    assign r = rgb_q[PW-1 -: CW];
    assign g = rgb_q[2*CW-1 -: CW];
    assign b = rgb_q[CW-1:0];

endmodule

// File: tb/tb_vga_row_pattern_gen.sv
// tb/tb_vga_row_pattern_gen.sv - scoreboard bench against a frame-level reference model
module tb_vga_row_pattern_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 12;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int RS = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b1;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [5:0] base_color = 6'd0;
    logic       scroll_en = 1'b0;
    logic       hsync, vsync, de, frame_start;
    logic [1:0] r, g, b;
    logic [4:0] hpos, vpos;

    always #5 clk = ~clk;

    vga_row_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .ROW_SHIFT (RS), .CW (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .mode        (mode),
        .base_color  (base_color),
        .scroll_en   (scroll_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .r           (r),
        .g           (g),
        .b           (b),
        .frame_start (frame_start),
        .hpos        (hpos),
        .vpos        (vpos)
    );

    // {hsync, vsync, de, frame_start, rgb[5:0], hpos[4:0], vpos[4:0]}
    logic [19:0] exp_q[$];
    logic [19:0] last_exp;
    int checks = 0;
    int errors = 0;

    // Reference state: enabled clocks since reset, and the per-frame control snapshot.
    int k;
    int m_mode, m_col, m_se, m_off;

    task automatic model_step();
        int h, v, y, band, pix;
        logic e_hs, e_vs, e_de, e_fs;
        if (!rst_n) begin
            k = 0; m_mode = 0; m_col = 0; m_se = 0; m_off = 0;
            last_exp = {1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 5'd0};
        end else if (!ena) begin
            last_exp[16] = 1'b0;
        end else begin
            h = k % HT;
            v = (k / HT) % VT;
            e_fs = (h == 0) && (v == 0);
            if (e_fs) begin
                m_off  = (m_off + m_se) % VT;
                m_mode = int'(mode);
                m_col  = int'(base_color);
                m_se   = int'(scroll_en);
            end
            e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
            e_de = (h < HA) && (v < VA);
            y    = (v + m_off) % VT;
            band = (y / (1 << RS)) % 64;
            case (m_mode)
                0:       pix = 0;
                1:       pix = m_col;
                2:       pix = (m_col + band) % 64;
                default: pix = (((band % 2) != ((h / (1 << RS)) % 2))) ? (m_col ^ 63) : m_col;
            endcase
            if (!e_de) pix = 0;
            k++;
            last_exp = {e_hs, e_vs, e_de, e_fs, 6'(pix), 5'(k % HT), 5'((k / HT) % VT)};
        end
        exp_q.push_back(last_exp);
    endtask

    task automatic step(input logic rn, input logic en, input logic [1:0] md,
                        input logic [5:0] bc, input logic se);
        @(negedge clk);
        rst_n = rn; ena = en; mode = md; base_color = bc; scroll_en = se;
        model_step();
    endtask

    initial begin : monitor
        logic [19:0] e, act;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow t=%0t actual=no_expected required=expected_entry", $time);
            end else begin
                e   = exp_q.pop_front();
                act = {hsync, vsync, de, frame_start, r, g, b, hpos, vpos};
                if (act !== e) begin
                    errors++;
                    $display("FAIL pixel_out t=%0t actual=%h required=%h (hs,vs,de,fs,rgb,hpos,vpos)",
                             $time, act, e);
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
        // Row bands from black base, no scroll.
        for (int i = 0; i < 2 * FT; i++) step(1'b1, 1'b1, 2'd2, 6'h00, 1'b0);
        // Solid colour changed mid-frame only shows from the following frame.
        for (int i = 0; i < 3 * FT; i++)
            step(1'b1, 1'b1, 2'd1, (i < FT + FT / 2) ? 6'h00 : 6'h3F, 1'b0);
        // Freeze for 50 clocks mid-line.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'd1, 6'h15, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 2'd1, 6'h15, 1'b0);
        for (int i = 0; i < FT; i++) step(1'b1, 1'b1, 2'd1, 6'h15, 1'b0);
        // Scrolling long enough for the offset to wrap past V_TOTAL-1.
        for (int i = 0; i < (VT + 3) * FT; i++) step(1'b1, 1'b1, 2'd2, 6'h05, 1'b1);
        // Checker pattern.
        for (int i = 0; i < 2 * FT; i++) step(1'b1, 1'b1, 2'd3, 6'h2A, 1'b0);
        // Reset asserted mid-frame, then restart.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd3, 6'h2A, 1'b1);
        for (int i = 0; i < FT; i++) step(1'b1, 1'b1, 2'd2, 6'h11, 1'b1);
        // Randomised controls and enable gaps.
        for (int i = 0; i < 40000; i++)
            step(1'b1, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
